ustore_loader: RTL and testbench

- Parametrised microprogram control store for the MIC-1 datapath: synchronous RAM of microinstructions with one read port, one direct write port and a streaming microcode loader.
- The loader uses a valid/ready handshake with an auto-incrementing address.
- Each word is stored with an even-parity bit, checked on every read.
- Optional output register for timing; sits between the microsequencer (raddr = MPC) and the MIR.

---
 rtl/ustore_loader.sv | 170 +++++++++++++++++
 tb/tb_ustore_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ustore_loader.sv
// MIC-1 microprogram control store: parity-protected synchronous RAM with one read port,
// a direct write port and a valid/ready streaming loader with auto-incrementing address.
module ustore_loader #(
    parameter int unsigned DATA_W    = 36,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned OUT_REG   = 0,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              parity_err,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              perr_inject,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_count,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              busy,
    output logic              load_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef logic [DATA_W:0] word_t;
    typedef word_t mem_t [DEPTH];
    typedef enum logic [0:0] {StIdle, StLoad} state_e;

    function automatic mem_t init_mem();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m[i] = '0;
        end
        return m;
    endfunction

    mem_t mem_q = init_mem();

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                ld_ready_q, ld_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                perr1_q, perr1_d;
    logic                rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]   rdata2_q, rdata2_d;
    logic                perr2_q, perr2_d;
    logic                rvalid2_q, rvalid2_d;

    word_t               rword;
    logic                ld_fire;
    logic                dir_fire;

    assign ld_fire  = ld_valid && ld_ready_q;
    assign dir_fire = wen && (state_q == StIdle);

    // Non-blocking update gives read-first behaviour for a same-address read and write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (ld_fire) begin
                mem_q[ptr_q] <= {^ld_data, ld_data};
            end else if (dir_fire) begin
                mem_q[waddr] <= {(^wdata) ^ perr_inject, wdata};
            end
        end
    end

    always_comb begin
        rword     = mem_q[raddr];
        rvalid1_d = ren;
        rdata1_d  = rdata1_q;
        perr1_d   = perr1_q;
        if (ren) begin
            rdata1_d = rword[DATA_W-1:0];
            perr1_d  = (^rword[DATA_W-1:0]) != rword[DATA_W];
        end
        rvalid2_d = rvalid1_q;
        rdata2_d  = rdata2_q;
        perr2_d   = perr2_q;
        if (rvalid1_q) begin
            rdata2_d = rdata1_q;
            perr2_d  = perr1_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        ld_ready_d = ld_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    if (load_count != '0) begin
                        state_d    = StLoad;
                        ptr_d      = load_base;
                        rem_d      = load_count;
                        ld_ready_d = 1'b1;
                        busy_d     = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (ld_fire) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    rem_d = rem_q - (ADDR_W + 1)'(1);
                    if (rem_q == (ADDR_W + 1)'(1)) begin
                        state_d    = StIdle;
                        ld_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            rem_q      <= '0;
            ld_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rdata1_q   <= '0;
            perr1_q    <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata2_q   <= '0;
            perr2_q    <= 1'b0;
            rvalid2_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            ld_ready_q <= ld_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rdata1_q   <= rdata1_d;
            perr1_q    <= perr1_d;
            rvalid1_q  <= rvalid1_d;
            rdata2_q   <= rdata2_d;
            perr2_q    <= perr2_d;
            rvalid2_q  <= rvalid2_d;
        end
    end

    assign rdata      = (OUT_REG != 0) ? rdata2_q  : rdata1_q;
    assign rvalid     = (OUT_REG != 0) ? rvalid2_q : rvalid1_q;
    assign parity_err = (OUT_REG != 0) ? perr2_q   : perr1_q;
    assign ld_ready   = ld_ready_q;
    assign busy       = busy_q;
    assign load_done  = done_q;

endmodule

// File: tb/tb_ustore_loader.sv
// Bench for ustore_loader: drives one latency-1 and one latency-2 instance with shared stimulus
// and scores reads against a reference memory through per-instance queues.
module tb_ustore_loader;

    localparam int DW    = 36;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, ren, wen, perr_inject, load_start, ld_valid;
    logic [AW-1:0] raddr, waddr, load_base;
    logic [AW:0]   load_count;
    logic [DW-1:0] wdata, ld_data;

    logic [DW-1:0] rdata0, rdata1;
    logic          rvalid0, rvalid1, perr0, perr1;
    logic          ld_ready0, ld_ready1, busy0, busy1, done0, done1;

    logic [DW-1:0] m_data [DEPTH];
    logic          m_perr [DEPTH];
    logic [AW-1:0] m_ptr;
    logic [AW:0]   m_rem;
    logic          m_busy, m_done;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ustore_loader #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .INIT_FILE("")) dut0 (
        .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0),
        .parity_err(perr0), .wen(wen), .waddr(waddr), .wdata(wdata), .perr_inject(perr_inject),
        .load_start(load_start), .load_base(load_base), .load_count(load_count),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready0), .busy(busy0),
        .load_done(done0)
    );

    ustore_loader #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .INIT_FILE("")) dut1 (
        .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1),
        .parity_err(perr1), .wen(wen), .waddr(waddr), .wdata(wdata), .perr_inject(perr_inject),
        .load_start(load_start), .load_base(load_base), .load_count(load_count),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready1), .busy(busy1),
        .load_done(done1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to the next drive slot (2 ns after the edge) and check the control outputs.
    task automatic nxt();
        @(posedge clk);
        #2;
        ren = 1'b0; wen = 1'b0; perr_inject = 1'b0; load_start = 1'b0; ld_valid = 1'b0;
        check("busy0", 64'(busy0), 64'(m_busy));
        check("busy1", 64'(busy1), 64'(m_busy));
        check("ld_ready0", 64'(ld_ready0), 64'(m_busy));
        check("ld_ready1", 64'(ld_ready1), 64'(m_busy));
        check("load_done0", 64'(done0), 64'(m_done));
        check("load_done1", 64'(done1), 64'(m_done));
        m_done = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        ren = 1'b1;
        raddr = a;
        q0.push_back('{m_data[a], m_perr[a], cyc + 1});
        q1.push_back('{m_data[a], m_perr[a], cyc + 2});
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic inj);
        wen = 1'b1; waddr = a; wdata = d; perr_inject = inj;
        if (!m_busy) begin
            m_data[a] = d;
            m_perr[a] = inj;
        end
    endtask

    task automatic start_load(input logic [AW-1:0] b, input logic [AW:0] c);
        load_start = 1'b1; load_base = b; load_count = c;
        if (!m_busy) begin
            if (c == 0) begin
                m_done = 1'b1;
            end else begin
                m_busy = 1'b1; m_ptr = b; m_rem = c;
            end
        end
    endtask

    task automatic ld_word(input logic [DW-1:0] d);
        ld_valid = 1'b1; ld_data = d;
        if (m_busy) begin
            m_data[m_ptr] = d;
            m_perr[m_ptr] = 1'b0;
            m_ptr = AW'(m_ptr + 1);
            m_rem = (AW + 1)'(m_rem - 1);
            if (m_rem == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    function automatic logic [DW-1:0] mk(input int i);
        return {4'(i), 32'hC0DE0000 ^ 32'(i * 37)};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rvalid0) begin
            if (q0.size() == 0) begin
                check("rvalid0_spurious", 64'(rvalid0), 64'(0));
            end else begin
                e = q0.pop_front();
                check("rdata0", 64'(rdata0), 64'(e.data));
                check("parity_err0", 64'(perr0), 64'(e.perr));
                check("latency0", 64'(cyc), 64'(e.due));
            end
        end else if (q0.size() > 0 && q0[0].due <= cyc) begin
            check("rvalid0_missing", 64'(rvalid0), 64'(1));
            void'(q0.pop_front());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rvalid1) begin
            if (q1.size() == 0) begin
                check("rvalid1_spurious", 64'(rvalid1), 64'(0));
            end else begin
                e = q1.pop_front();
                check("rdata1", 64'(rdata1), 64'(e.data));
                check("parity_err1", 64'(perr1), 64'(e.perr));
                check("latency1", 64'(cyc), 64'(e.due));
            end
        end else if (q1.size() > 0 && q1[0].due <= cyc) begin
            check("rvalid1_missing", 64'(rvalid1), 64'(1));
            void'(q1.pop_front());
        end
    end

    initial begin
        rst = 1'b1; ren = 1'b0; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0;
        perr_inject = 1'b0; load_start = 1'b0; load_base = '0; load_count = '0;
        ld_valid = 1'b0; ld_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0;
            m_perr[i] = 1'b0;
        end
        m_ptr = '0; m_rem = '0; m_busy = 1'b0; m_done = 1'b0;

        nxt();
        nxt();
        check("rst_rdata0", 64'(rdata0), 64'(0));
        check("rst_rdata1", 64'(rdata1), 64'(0));
        check("rst_rvalid0", 64'(rvalid0), 64'(0));
        check("rst_rvalid1", 64'(rvalid1), 64'(0));
        check("rst_perr0", 64'(perr0), 64'(0));
        rst = 1'b0;
        nxt();

        // Direct write then read back
        wr(4'd3, 36'h123456789, 1'b0);
        nxt();
        rd(4'd3);
        nxt();
        nxt();

        // Wrapping load with valid gaps; direct write and restart while busy are ignored
        start_load(4'd14, 5'd4);
        nxt();
        nxt();
        ld_word(36'hA0000000A);
        nxt();
        nxt();
        ld_word(36'hB0000000B);
        nxt();
        wr(4'd5, 36'h0BAD00BAD, 1'b0);
        start_load(4'd2, 5'd3);
        ld_word(36'hC0000000C);
        nxt();
        ld_word(36'hD0000000D);
        nxt();
        nxt();
        foreach (m_data[i]) begin
            if (i == 14 || i == 15 || i == 0 || i == 1 || i == 5) begin
                rd(AW'(i));
                nxt();
            end
        end

        // Zero-length load only pulses load_done
        start_load(4'd6, 5'd0);
        nxt();
        nxt();

        // Parity error injection and repair
        wr(4'd7, 36'hF0F0F0F0F, 1'b1);
        nxt();
        rd(4'd7);
        nxt();
        wr(4'd7, 36'h000000001, 1'b0);
        nxt();
        rd(4'd7);
        nxt();

        // Back-to-back reads with a same-cycle read/write of address 2
        wr(4'd1, 36'h111111111, 1'b0);
        nxt();
        wr(4'd2, 36'h222222222, 1'b0);
        nxt();
        rd(4'd1);
        nxt();
        rd(4'd2);
        wr(4'd2, 36'h2EEEEEEE2, 1'b0);
        nxt();
        rd(4'd3);
        nxt();
        rd(4'd2);
        nxt();

        // Full-depth load starting mid-array
        start_load(4'd5, 5'd16);
        nxt();
        for (int i = 0; i < DEPTH; i++) begin
            if (i % 5 == 2) nxt();
            ld_word(mk(i));
            nxt();
        end
        nxt();
        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i));
            nxt();
        end
        nxt();
        nxt();

        // Reset in the middle of a load: third word on the reset edge is dropped
        start_load(4'd8, 5'd4);
        nxt();
        ld_word(36'h5A5A5A5A0);
        nxt();
        ld_word(36'h5A5A5A5A1);
        nxt();
        rst = 1'b1;
        ld_valid = 1'b1;
        ld_data = 36'h5A5A5A5A2;
        m_busy = 1'b0;
        m_done = 1'b0;
        q0.delete();
        q1.delete();
        nxt();
        check("midrst_rdata0", 64'(rdata0), 64'(0));
        check("midrst_rvalid0", 64'(rvalid0), 64'(0));
        check("midrst_rdata1", 64'(rdata1), 64'(0));
        check("midrst_rvalid1", 64'(rvalid1), 64'(0));
        rst = 1'b0;
        nxt();
        rd(4'd8);
        nxt();
        rd(4'd9);
        nxt();
        rd(4'd10);
        nxt();

        repeat (4) nxt();
        check("scoreboard_drain", 64'(q0.size() + q1.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
